// File: rtl/slb_unit_if.sv
// Memory-side bus of the store/load buffer: one-cycle request pulse, completion on mem_done.
interface slb_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_done;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_done, mem_rdata
  );
endinterface

// File: rtl/slb_unit.sv
// In-order store/load buffer: circular FIFO feeding one memory port, with tag wakeup and flush.
// Optional stall counter output stall_cnt is built only when SLB_PERF_CNT_EN is defined.
module slb_unit #(
  parameter int Q_WIDTH   = 4,
  parameter int SLB_WIDTH = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               has_issue,
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [31:0]        imm,
  input  logic [31:0]        Vj,
  input  logic [Q_WIDTH-1:0] Qj,
  input  logic [31:0]        Vk,
  input  logic [Q_WIDTH-1:0] Qk,
  input  logic [Q_WIDTH-1:0] rob_tag,
  input  logic               has_ex_result,
  input  logic [Q_WIDTH-1:0] target_ROB_pos,
  input  logic [31:0]        V_ex,
  input  logic               has_commit,
  input  logic               control_hazard,
  slb_unit_if.master         bus,
  output logic               has_slb_result,
  output logic [Q_WIDTH-1:0] slb_target_ROB_pos,
  output logic [31:0]        V_slb,
  output logic               full
`ifdef SLB_PERF_CNT_EN
  ,output logic [31:0]       stall_cnt
`endif
);
  localparam int DEPTH = 1 << SLB_WIDTH;

  typedef logic [SLB_WIDTH-1:0] ptr_t;
  typedef logic [SLB_WIDTH:0]   cnt_t;
  localparam ptr_t PTR_ONE  = 1;
  localparam cnt_t CNT_ONE  = 1;
  localparam cnt_t CNT_FULL = DEPTH;

  typedef struct packed {
    logic               valid;
    logic               store;
    logic               cmt;
    logic [2:0]         f3;
    logic [31:0]        imm;
    logic [31:0]        vj;
    logic [31:0]        vk;
    logic [Q_WIDTH-1:0] qj;
    logic [Q_WIDTH-1:0] qk;
    logic [Q_WIDTH-1:0] tag;
  } ent_t;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} st_t;

  ent_t ents [DEPTH];
  ptr_t head, tail;
  cnt_t count;
  st_t  state, state_nx;

  ent_t        hd, ne;
  logic        head_rdy, start, retire, res_vld, do_issue;
  logic        cmt_hit;
  ptr_t        cmt_idx, scan;
  logic [DEPTH-1:0] hold;
  cnt_t        keep;
  ptr_t        head_nx;
  logic [31:0] ld_val;

  function automatic logic hit_ex(input logic [Q_WIDTH-1:0] q);
    return (q != '0) && has_ex_result && (target_ROB_pos == q);
  endfunction

  function automatic logic hit_slb(input logic [Q_WIDTH-1:0] q);
    return (q != '0) && has_slb_result && (slb_target_ROB_pos == q);
  endfunction

  assign hd       = ents[head];
  assign head_rdy = hd.valid && (hd.qj == '0) && (!hd.store || ((hd.qk == '0) && hd.cmt));
  assign full     = (count == CNT_FULL);
  assign do_issue = rdy_in && has_issue && !control_hazard && (!full || retire);
  assign head_nx  = retire ? head + PTR_ONE : head;

  // Oldest uncommitted store, scanning from head in age order.
  always_comb begin
    cmt_hit = 1'b0;
    cmt_idx = head;
    scan    = head;
    for (int i = 0; i < DEPTH; i++) begin
      scan = head + ptr_t'(i);
      if (!cmt_hit && ents[scan].valid && ents[scan].store && !ents[scan].cmt) begin
        cmt_hit = 1'b1;
        cmt_idx = scan;
      end
    end
  end

  // Entries surviving a flush: committed (including this cycle's commit), minus a retiring head.
  always_comb begin
    keep = '0;
    hold = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hold[i] = ents[i].valid
              && (ents[i].cmt || (has_commit && cmt_hit && (cmt_idx == ptr_t'(i))))
              && !(retire && (head == ptr_t'(i)));
      if (hold[i]) keep = keep + CNT_ONE;
    end
  end

  always_comb begin
    ne       = '0;
    ne.valid = 1'b1;
    ne.store = is_store;
    ne.f3    = funct3;
    ne.imm   = imm;
    ne.tag   = rob_tag;
    ne.vj    = Vj;
    ne.qj    = Qj;
    ne.vk    = Vk;
    ne.qk    = Qk;
    if (hit_ex(Qj)) begin
      ne.vj = V_ex;
      ne.qj = '0;
    end else if (hit_slb(Qj)) begin
      ne.vj = V_slb;
      ne.qj = '0;
    end
    if (hit_ex(Qk)) begin
      ne.vk = V_ex;
      ne.qk = '0;
    end else if (hit_slb(Qk)) begin
      ne.vk = V_slb;
      ne.qk = '0;
    end
  end

  // A flushed load that completes in the same cycle retires silently.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    retire   = 1'b0;
    res_vld  = 1'b0;
    if (rdy_in) begin
      case (state)
        IDLE: if (head_rdy && (hd.store || !control_hazard)) begin
          start    = 1'b1;
          state_nx = BUSY;
        end
        BUSY: if (bus.mem_done) begin
          retire   = 1'b1;
          res_vld  = !hd.store && !control_hazard;
          state_nx = IDLE;
        end else if (control_hazard && !hd.store) begin
          state_nx = DRAIN;
        end
        DRAIN: if (bus.mem_done) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    case (hd.f3)
      3'b000:  ld_val = {{24{bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
      3'b001:  ld_val = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      3'b100:  ld_val = {24'h0, bus.mem_rdata[7:0]};
      3'b101:  ld_val = {16'h0, bus.mem_rdata[15:0]};
      default: ld_val = bus.mem_rdata;
    endcase
  end

  assign bus.mem_req   = start;
  assign bus.mem_we    = start && hd.store;
  assign bus.mem_addr  = start ? hd.vj + hd.imm : 32'h0;
  assign bus.mem_wdata = start ? hd.vk : 32'h0;
  assign bus.mem_size  = start ? hd.f3[1:0] : 2'd0;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state              <= IDLE;
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      has_slb_result     <= 1'b0;
      slb_target_ROB_pos <= '0;
      V_slb              <= '0;
      for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
    end else if (rdy_in) begin
      state              <= state_nx;
      has_slb_result     <= res_vld;
      slb_target_ROB_pos <= res_vld ? hd.tag : '0;
      V_slb              <= res_vld ? ld_val : 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        if (ents[i].valid) begin
          if (hit_ex(ents[i].qj)) begin
            ents[i].vj <= V_ex;
            ents[i].qj <= '0;
          end else if (hit_slb(ents[i].qj)) begin
            ents[i].vj <= V_slb;
            ents[i].qj <= '0;
          end
          if (hit_ex(ents[i].qk)) begin
            ents[i].vk <= V_ex;
            ents[i].qk <= '0;
          end else if (hit_slb(ents[i].qk)) begin
            ents[i].vk <= V_slb;
            ents[i].qk <= '0;
          end
        end
      end
      if (has_commit && cmt_hit) ents[cmt_idx].cmt <= 1'b1;
      if (retire) ents[head].valid <= 1'b0;
      if (control_hazard) begin
        for (int i = 0; i < DEPTH; i++)
          if (!hold[i]) ents[i].valid <= 1'b0;
        head  <= head_nx;
        tail  <= head_nx + keep[SLB_WIDTH-1:0];
        count <= keep;
      end else begin
        // Written last so an issue into the slot freed by a retiring head wins.
        if (do_issue) begin
          ents[tail] <= ne;
          tail       <= tail + PTR_ONE;
        end
        head <= head_nx;
        case ({do_issue, retire})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef SLB_PERF_CNT_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      stall_cnt <= 32'h0;
    else if (rdy_in && hd.valid && (state == IDLE) && !start && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
